// File: rtl/coproc_pkg.sv
// Shared definitions for the 2-bit-addressed coprocessor bus, used by the master
// and by device-side adapters.
package coproc_pkg;

  localparam logic [5:0]  OP_CLEAR       = 6'h3F;
  localparam logic [31:0] BUS_IDLE       = 32'hFFFF_FFFF;
  localparam int          RESP_VALID_BIT = 31;
  localparam int          ADDR_HI        = 30;
  localparam int          ADDR_LO        = 29;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} state_t;

  typedef struct packed {
    logic [1:0]  addr;
    logic [5:0]  op;
    logic [23:0] data;
  } bus_word_t;

  function automatic logic [31:0] make_word(input logic [1:0] dev, input logic [5:0] op,
                                            input logic [23:0] data);
    bus_word_t w;
    w.addr = dev;
    w.op   = op;
    w.data = data;
    return w;
  endfunction

endpackage

// File: rtl/coproc_resp_sel.sv
// Picks the addressed device's result word and interrupt and decides whether it
// is a valid post for that device. Purely combinational.
module coproc_resp_sel
  import coproc_pkg::*;
(
  input  logic [1:0]   dev,
  input  logic [127:0] bus_in,
  input  logic [3:0]   bus_irq,
  output logic         match,
  output logic [23:0]  payload
);

  logic [3:0][31:0] words;
  logic [31:0]      sel;
  logic             unused_rsvd;

  assign words   = bus_in;
  assign sel     = words[dev];
  // The address echo guards against a device posting into the wrong slot.
  assign match   = bus_irq[dev] & sel[RESP_VALID_BIT] & (sel[ADDR_HI:ADDR_LO] == dev);
  assign payload = sel[23:0];
  // Bits [28:24] of a result word carry no meaning for the master.
  assign unused_rsvd = ^sel[28:24];

endmodule

// File: rtl/coproc_master.sv
// CPU-side initiator: issues one command, waits for the device post or a timeout,
// clears the device and returns a single-cycle response to the core.
module coproc_master
  import coproc_pkg::*;
#(
  parameter  int TIMEOUT = 1024,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_dev,
  input  logic [5:0]   req_op,
  input  logic [23:0]  req_data,
  output logic         rsp_valid,
  output logic [23:0]  rsp_data,
  output logic         rsp_err,
  output logic         busy,
  output logic [31:0]  bus_out,
  input  logic [127:0] bus_in,
  input  logic [3:0]   bus_irq
);

  state_t            state, next_state;
  logic [1:0]        dev, dev_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [31:0]       bus_d;
  logic              rsp_valid_d, rsp_err_d;
  logic [23:0]       rsp_data_d;
  logic              match, timeout;
  logic [23:0]       payload;

  coproc_resp_sel u_sel (
    .dev     (dev),
    .bus_in  (bus_in),
    .bus_irq (bus_irq),
    .match   (match),
    .payload (payload)
  );

  assign timeout   = (cnt == CNT_W'(TIMEOUT - 1));
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dev       <= '0;
      cnt       <= '0;
      bus_out   <= BUS_IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= next_state;
      dev       <= dev_d;
      cnt       <= cnt_d;
      bus_out   <= bus_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = (req_op == OP_CLEAR) ? ACK : WAIT;
      WAIT:    if (match || timeout) next_state = ACK;
      ACK:     next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; the bus falls back to the idle word.
  always_comb begin
    bus_d       = BUS_IDLE;
    dev_d       = dev;
    cnt_d       = cnt;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    case (state)
      IDLE: if (req_valid) begin
        dev_d = req_dev;
        cnt_d = '0;
        if (req_op == OP_CLEAR) begin
          bus_d       = make_word(req_dev, OP_CLEAR, 24'h0);
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
        end else begin
          bus_d = make_word(req_dev, req_op, req_data);
        end
      end
      WAIT: begin
        cnt_d = cnt + CNT_W'(1);
        if (match) begin
          bus_d       = make_word(dev, OP_CLEAR, 24'h0);
          rsp_valid_d = 1'b1;
          rsp_data_d  = payload;
          rsp_err_d   = 1'b0;
        end else if (timeout) begin
          bus_d       = make_word(dev, OP_CLEAR, 24'h0);
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coproc_master.sv
// Bench for coproc_master: directed and random commands against a cycle-level
// model of when each word, response and busy level must appear.
module tb_coproc_master;

  localparam int TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_dev;
  logic [5:0]   req_op;
  logic [23:0]  req_data;
  logic         rsp_valid;
  logic [23:0]  rsp_data;
  logic         rsp_err;
  logic         busy;
  logic [31:0]  bus_out;
  logic [127:0] bus_in;
  logic [3:0]   bus_irq;

  int checks = 0;
  int errors = 0;

  coproc_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dev   (req_dev),
    .req_op    (req_op),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .bus_out   (bus_out),
    .bus_in    (bus_in),
    .bus_irq   (bus_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word layout from plain arithmetic: addr * 2^30 + op * 2^24 + data.
  function automatic logic [31:0] word_of(input int dev, input int op, input int data);
    longint w;
    w = longint'(dev) * 64'h4000_0000 + longint'(op) * 64'h100_0000 + longint'(data);
    return w[31:0];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Background noise: every result word lacks the valid bit, interrupts random.
  task automatic drive_idle_bus();
    for (int o = 0; o < 4; o++) bus_in[32*o +: 32] = $urandom & 32'h7FFF_FFFF;
    bus_irq = 4'($urandom);
  endtask

  task automatic inject_stray(input int dev);
    int         o;
    logic [1:0] bad;
    case ($urandom % 4)
      0: begin
        o = (dev + 1 + int'($urandom % 3)) % 4;
        bus_in[32*o +: 32] = {1'b1, 2'(o), 29'($urandom)};
        bus_irq[o] = 1'b1;
      end
      1: begin
        bus_in[32*dev +: 32] = {1'b0, 2'(dev), 29'($urandom)};
        bus_irq[dev] = 1'b1;
      end
      2: begin
        bad = 2'(dev) ^ 2'(1 + $urandom % 3);
        bus_in[32*dev +: 32] = {1'b1, bad, 29'($urandom)};
        bus_irq[dev] = 1'b1;
      end
      default: begin
        bus_in[32*dev +: 32] = {1'b1, 2'(dev), 29'($urandom)};
        bus_irq[dev] = 1'b0;
      end
    endcase
  endtask

  // One command issued in cycle T. The device posts in cycle T+1+d. Cycle j is T+j;
  // the response lands in cycle A, the master is idle again in cycle A+2.
  task automatic run_cmd(input int dev, input int op, input int data, input int d, input bit stray);
    int          a;
    bit          flush;
    logic [23:0] payload;
    logic [23:0] exp_data;
    logic        exp_err;
    logic [31:0] exp_bus;
    flush   = (op == 63);
    payload = 24'($urandom);
    if (flush) begin
      a = 1; exp_data = 0; exp_err = 0;
    end else if (d <= TIMEOUT - 1) begin
      a = d + 2; exp_data = payload; exp_err = 0;
    end else begin
      a = TIMEOUT + 1; exp_data = 0; exp_err = 1;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    req_valid = 1'b1;
    req_dev   = 2'(dev);
    req_op    = 6'(op);
    req_data  = 24'(data);
    drive_idle_bus();
    for (int j = 1; j <= a + 2; j++) begin
      tick();
      if (j == 1)
        exp_bus = flush ? word_of(dev, 63, 0) : word_of(dev, op, data);
      else if (j == a)
        exp_bus = word_of(dev, 63, 0);
      else
        exp_bus = 32'hFFFF_FFFF;
      check("bus_out", bus_out, exp_bus);
      check("rsp_valid", 32'(rsp_valid), 32'(j == a));
      check("busy", 32'(busy), 32'(j <= a + 1));
      check("req_ready", 32'(req_ready), 32'(j > a + 1));
      if (j == a) begin
        check("rsp_data", 32'(rsp_data), 32'(exp_data));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
      end
      req_valid = (j <= a + 1) ? 1'($urandom) : 1'b0;
      req_dev   = 2'($urandom);
      req_op    = 6'($urandom);
      req_data  = 24'($urandom);
      drive_idle_bus();
      if (stray && j < a) inject_stray(dev);
      if (!flush && j == d + 1) begin
        bus_in[32*dev +: 32] = {1'b1, 2'(dev), 5'($urandom), payload};
        bus_irq[dev] = 1'b1;
      end
      if ((j == a || j == a + 1) && $urandom % 2 == 1) begin
        bus_in[32*dev +: 32] = {1'b1, 2'(dev), 5'($urandom), 24'($urandom)};
        bus_irq[dev] = 1'b1;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_dev   = '0;
    req_op    = '0;
    req_data  = '0;
    bus_in    = '0;
    bus_irq   = '0;
    tick();
    check("rst_bus_out", bus_out, 32'hFFFF_FFFF);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Directed cases
    run_cmd(2, 6'h01, 24'h00_1234, 3, 0);
    run_cmd(0, 6'h05, 24'h5A_5A5A, 1, 0);
    run_cmd(1, 6'h02, 24'h00_0042, 99, 0);
    run_cmd(1, 6'h07, 24'h11_1111, TIMEOUT - 1, 0);
    run_cmd(1, 6'h03, 24'h22_2222, TIMEOUT, 0);
    run_cmd(1, 6'h04, 24'h33_3333, 4, 1);
    run_cmd(2, 6'h3F, 24'h12_3456, 2, 0);
    run_cmd(3, 6'h3E, 24'hFF_FFFF, 2, 1);

    // Reset while waiting on a silent device; a late post must be ignored.
    req_valid = 1'b1; req_dev = 2'd1; req_op = 6'h05; req_data = 24'h00_0777;
    drive_idle_bus();
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("mid_wait_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_bus_out", bus_out, 32'hFFFF_FFFF);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_req_ready", 32'(req_ready), 32'd1);
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_in[63:32] = {1'b1, 2'd1, 5'd0, 24'($urandom)};
      bus_irq[1]    = 1'b1;
      tick();
      check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_bus_out", bus_out, 32'hFFFF_FFFF);
    end
    drive_idle_bus();

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      run_cmd(int'($urandom % 4),
              ($urandom % 8 == 0) ? 63 : int'($urandom % 63),
              int'($urandom & 24'hFF_FFFF),
              1 + int'($urandom % 10),
              1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
